// File: rtl/ami_r_arb.sv
// Round-robin AR arbiter that merges NCH user read ports onto one AXI master.
// The R channel is routed back to the owning port from the upper RID bits.
module ami_r_arb #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 40,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int NCH    = 4,
    parameter int AMI_OD = 4,
    localparam int CHW   = $clog2(NCH),
    localparam int UIW   = AXI_IW - CHW
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    output logic [AXI_IW-1:0]           ARID,
    output logic [AXI_AW-1:0]           ARADDR,
    output logic [AXI_LW-1:0]           ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [AXI_IW-1:0]           RID,
    input  logic [AXI_DW-1:0]           RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic [NCH-1:0][UIW-1:0]     usr_arid,
    input  logic [NCH-1:0][AXI_AW-1:0]  usr_araddr,
    input  logic [NCH-1:0][AXI_LW-1:0]  usr_arlen,
    input  logic [NCH-1:0]              usr_arvalid,
    output logic [NCH-1:0]              usr_arready,
    output logic [UIW-1:0]              usr_rid,
    output logic [AXI_DW-1:0]           usr_rdata,
    output logic [1:0]                  usr_rresp,
    output logic                        usr_rlast,
    output logic [NCH-1:0]              usr_rvalid,
    input  logic [NCH-1:0]              usr_rready,
    output logic [NCH-1:0]              stat_err
);

    localparam int CW = $clog2(AMI_OD + 1);
    localparam logic [CW-1:0] OD = CW'(AMI_OD);

    logic [NCH-1:0][CW-1:0] out_cnt;
    logic [CHW-1:0]         rr_ptr;
    logic [CHW-1:0]         rr_next;
    logic [CHW-1:0]         win;
    logic [CHW-1:0]         idx;
    logic [NCH-1:0]         elig;
    logic [NCH-1:0]         inc;
    logic [NCH-1:0]         dec;
    logic                   found;
    logic                   load;
    logic [CHW-1:0]         ch;
    logic                   mapped;
    logic                   r_hs;

    assign ARSIZE  = 3'($clog2(AXI_DW / 8));
    assign ARBURST = 2'b01;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            elig[i] = usr_arvalid[i] && (out_cnt[i] < OD);
        end
    end

    // First eligible port at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CHW'((int'(rr_ptr) + k) % NCH);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign load        = found && (!ARVALID || ARREADY) && !ARESET;
    assign usr_arready = load ? (NCH'(1) << win) : '0;
    assign rr_next     = (win == CHW'(NCH - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ARVALID <= 1'b0;
            ARID    <= '0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            ARVALID <= 1'b1;
            ARID    <= {win, usr_arid[win]};
            ARADDR  <= usr_araddr[win];
            ARLEN   <= usr_arlen[win];
            rr_ptr  <= rr_next;
        end else if (ARREADY) begin
            ARVALID <= 1'b0;
        end
    end

    assign ch = RID[AXI_IW-1 -: CHW];

    // Channel numbers past NCH only exist when NCH is not a power of two.
    generate
        if (NCH == (1 << CHW)) begin : g_full
            assign mapped = 1'b1;
        end else begin : g_part
            assign mapped = (ch < CHW'(NCH));
        end
    endgenerate

    assign RREADY    = mapped ? usr_rready[ch] : 1'b1;
    assign r_hs      = RVALID && RREADY && mapped;
    assign usr_rid   = RID[UIW-1:0];
    assign usr_rdata = RDATA;
    assign usr_rresp = RRESP;
    assign usr_rlast = RLAST;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            usr_rvalid[i] = RVALID && mapped && (ch == CHW'(i));
            inc[i]        = load && (win == CHW'(i));
            dec[i]        = r_hs && RLAST && (ch == CHW'(i));
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            out_cnt  <= '0;
            stat_err <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (inc[i] && !dec[i]) begin
                    out_cnt[i] <= out_cnt[i] + 1'b1;
                end else if (dec[i] && !inc[i] && out_cnt[i] != '0) begin
                    out_cnt[i] <= out_cnt[i] - 1'b1;
                end
                if (r_hs && RRESP[1] && (ch == CHW'(i))) begin
                    stat_err[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ami_r_arb.sv
// Bench for ami_r_arb: directed scenarios plus random traffic
// compared every cycle against a queue/array reference model.
module tb_ami_r_arb;

    localparam int NCH = 4;
    localparam int UIW = 6;
    localparam int IW  = 8;
    localparam int AW  = 40;
    localparam int DW  = 128;
    localparam int LW  = 8;
    localparam int OD  = 4;

    logic                    ACLK = 1'b0;
    logic                    ARESET;
    logic [IW-1:0]           ARID;
    logic [AW-1:0]           ARADDR;
    logic [LW-1:0]           ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [IW-1:0]           RID;
    logic [DW-1:0]           RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;
    logic [NCH-1:0][UIW-1:0] usr_arid;
    logic [NCH-1:0][AW-1:0]  usr_araddr;
    logic [NCH-1:0][LW-1:0]  usr_arlen;
    logic [NCH-1:0]          usr_arvalid;
    logic [NCH-1:0]          usr_arready;
    logic [UIW-1:0]          usr_rid;
    logic [DW-1:0]           usr_rdata;
    logic [1:0]              usr_rresp;
    logic                    usr_rlast;
    logic [NCH-1:0]          usr_rvalid;
    logic [NCH-1:0]          usr_rready;
    logic [NCH-1:0]          stat_err;

    ami_r_arb dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .usr_arid(usr_arid), .usr_araddr(usr_araddr),
        .usr_arlen(usr_arlen), .usr_arvalid(usr_arvalid),
        .usr_arready(usr_arready),
        .usr_rid(usr_rid), .usr_rdata(usr_rdata),
        .usr_rresp(usr_rresp), .usr_rlast(usr_rlast),
        .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
        .stat_err(stat_err)
    );

    always #5 ACLK = ~ACLK;

    int n_chk  = 0;
    int n_fail = 0;

    int             m_cnt [NCH];
    int             m_rr;
    bit             m_vld;
    logic [IW-1:0]  m_id;
    logic [AW-1:0]  m_addr;
    logic [LW-1:0]  m_len;
    logic [NCH-1:0] m_err;
    bit             m_init = 1'b0;
    int             gq [$];

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NCH; k++) begin
            int p;
            p = (m_rr + k) % NCH;
            if (usr_arvalid[p] && m_cnt[p] < OD) return p;
        end
        return -1;
    endfunction

    task automatic idle();
        ARESET      = 1'b0;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        RLAST       = 1'b0;
        RRESP       = 2'b00;
        RID         = '0;
        RDATA       = '0;
        usr_arvalid = '0;
        usr_rready  = '0;
    endtask

    task automatic rand_inputs();
        ARESET      = ($urandom % 150) == 0;
        ARREADY     = ($urandom % 10) < 7;
        RVALID      = 1'($urandom);
        RID         = 8'($urandom);
        RLAST       = 1'($urandom);
        RRESP       = {($urandom % 32) == 0, 1'($urandom)};
        RDATA       = {$urandom, $urandom, $urandom, $urandom};
        usr_arvalid = 4'($urandom);
        usr_rready  = 4'($urandom);
        for (int i = 0; i < NCH; i++) begin
            usr_arid[i]   = 6'($urandom);
            usr_araddr[i] = {8'($urandom), $urandom};
            usr_arlen[i]  = 8'($urandom);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        int       w;
        bit       eload;
        bit       hs;
        logic [1:0] ch;
        #2;
        w     = pick();
        eload = !ARESET && (!m_vld || ARREADY) && (w >= 0);
        ch    = RID[7:6];
        hs    = RVALID && usr_rready[ch];
        if (m_init) begin
            chk("usr_arready", usr_arready,
                eload ? (4'b0001 << w) : 4'b0000);
            chk("arvalid", ARVALID, m_vld);
            chk("arid", ARID, m_id);
            chk("araddr", ARADDR, m_addr);
            chk("arlen", ARLEN, m_len);
            chk("usr_rvalid", usr_rvalid,
                RVALID ? (4'b0001 << ch) : 4'b0000);
            chk("rready", RREADY, usr_rready[ch]);
            chk("usr_rid", usr_rid, RID[5:0]);
            chk("usr_rdata", usr_rdata, RDATA);
            chk("usr_rresp", usr_rresp, RRESP);
            chk("usr_rlast", usr_rlast, RLAST);
            chk("stat_err", stat_err, m_err);
            for (int i = 0; i < NCH; i++)
                chk("out_cnt", dut.out_cnt[i], m_cnt[i]);
            for (int i = 0; i < NCH; i++)
                if (usr_arready[i]) gq.push_back(i);
        end
        @(posedge ACLK);
        if (ARESET) begin
            m_vld  = 1'b0;
            m_id   = '0;
            m_addr = '0;
            m_len  = '0;
            m_rr   = 0;
            m_err  = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_init = 1'b1;
        end else begin
            if (eload) begin
                m_vld  = 1'b1;
                m_id   = {2'(w), usr_arid[w]};
                m_addr = usr_araddr[w];
                m_len  = usr_arlen[w];
                m_rr   = (w + 1) % NCH;
                m_cnt[w]++;
            end else if (ARREADY) begin
                m_vld = 1'b0;
            end
            if (hs && RLAST && m_cnt[ch] > 0) m_cnt[ch]--;
            if (hs && RRESP[1]) m_err[ch] = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        ARESET = 1'b1;
        step();
        step();
        ARESET = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [IW-1:0] hid;

    initial begin
        rand_inputs();
        do_reset();

        #1;
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_arid", ARID, 8'h00);
        chk("rst_stat_err", stat_err, 4'b0000);
        chk("rst_arready", usr_arready, 4'b0000);
        chk("arsize", ARSIZE, 3'd4);
        chk("arburst", ARBURST, 2'b01);

        usr_arvalid = 4'hF;
        ARREADY     = 1'b1;
        gq.delete();
        repeat (5) step();
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            chk("rr_order", gq[i], exp_order[i]);

        do_reset();
        usr_arvalid = 4'b0010;
        ARREADY     = 1'b1;
        gq.delete();
        repeat (4) step();
        chk("od_grants", gq.size(), 4);
        #1 chk("od_block", usr_arready[1], 1'b0);
        step();
        RVALID     = 1'b1;
        RID        = {2'd1, 6'h03};
        RLAST      = 1'b1;
        usr_rready = 4'b0010;
        #1 chk("od_still", usr_arready[1], 1'b0);
        step();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        #1 chk("od_regrant", usr_arready[1], 1'b1);
        step();

        do_reset();
        usr_arvalid = 4'hF;
        ARREADY     = 1'b0;
        step();
        hid = m_id;
        repeat (5) begin
            #1;
            chk("hold_arid", ARID, hid);
            chk("hold_arvalid", ARVALID, 1'b1);
            chk("hold_grant", usr_arready, 4'b0000);
            step();
        end
        ARREADY = 1'b1;
        step();

        idle();
        RVALID     = 1'b1;
        RID        = 8'hC5;
        usr_rready = 4'b1000;
        #1;
        chk("c5_rvalid", usr_rvalid, 4'b1000);
        chk("c5_rid", usr_rid, 6'h05);
        chk("c5_rready1", RREADY, 1'b1);
        usr_rready = 4'b0111;
        #1;
        chk("c5_rready0", RREADY, 1'b0);
        step();

        do_reset();
        RVALID     = 1'b1;
        RID        = {2'd2, 6'h01};
        RRESP      = 2'b10;
        usr_rready = 4'b0100;
        step();
        idle();
        #1 chk("err_set", stat_err, 4'b0100);
        repeat (3) step();
        chk("err_hold", stat_err, 4'b0100);
        usr_arvalid = 4'b0001;
        ARREADY     = 1'b1;
        step();
        RVALID     = 1'b1;
        RID        = 8'h00;
        RLAST      = 1'b1;
        usr_rready = 4'b0001;
        #1 chk("same_grant", usr_arready, 4'b0001);
        step();
        chk("same_cnt", dut.out_cnt[0], 1);
        do_reset();
        #1 chk("err_clear", stat_err, 4'b0000);

        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ami_r_arb.md
AMI_R_ARB -- requirements
Module: ami_r_arb

Interface
REQ-001 SHALL have parameter AXI_DW, default 128, AXI data bus width.
REQ-002 SHALL have parameter AXI_AW, default 40, AXI address width.
REQ-003 SHALL have parameter AXI_IW, default 8, AXI ID width.
REQ-004 SHALL have parameter AXI_LW, default 8, ARLEN width.
REQ-005 SHALL have parameter NCH, default 4, number of user read ports, legal range 2..16.
REQ-006 SHALL have parameter AMI_OD, default 4, max outstanding bursts per user port, legal range >=1.
REQ-007 SHALL have derived widths CHW=$clog2(NCH) and UIW=AXI_IW-CHW, the user ID width.
REQ-008 ACLK  in  1  single clock; all logic on its rising edge.
REQ-009 ARESET  in  1  reset, synchronous, active-high.
REQ-010 ARID  out  AXI_IW  {port index, user ID}.
REQ-011 ARADDR  out  AXI_AW  read address.
REQ-012 ARLEN  out  AXI_LW  burst length-1.
REQ-013 ARSIZE  out  3  constant $clog2(AXI_DW/8).
REQ-014 ARBURST  out  2  constant 2'b01 (INCR).
REQ-015 ARVALID  out  1  AR valid, registered.
REQ-016 ARREADY  in  1  AR ready.
REQ-017 RID / RDATA / RRESP / RLAST / RVALID  in  AXI_IW / AXI_DW / 2 / 1 / 1  AXI R channel.
REQ-018 RREADY  out  1  R ready.
REQ-019 usr_arid / usr_araddr / usr_arlen  in  [NCH][UIW] / [NCH][AXI_AW] / [NCH][AXI_LW]  per-port AR payload.
REQ-020 usr_arvalid  in  NCH  per-port AR request; usr_arready  out  NCH  per-port grant.
REQ-021 usr_rid / usr_rdata / usr_rresp / usr_rlast  out  UIW / AXI_DW / 2 / 1  R payload, shared by all ports.
REQ-022 usr_rvalid  out  NCH  per-port R valid; usr_rready  in  NCH  per-port R ready.
REQ-023 stat_err  out  NCH  per-port sticky error flag.

Function
REQ-024 Eligibility: port i SHALL be eligible when usr_arvalid[i]=1 and out_cnt[i]<AMI_OD.
REQ-025 Arbitration: round-robin, searching from port rr_ptr upward with modulo-NCH wrap; the first eligible port wins.
REQ-026 Load: the AR output register SHALL load the winner when (ARVALID=0 or ARREADY=1) and a winner exists; usr_arready[winner]=1 that cycle only; all other usr_arready bits 0.
REQ-027 On each load, rr_ptr SHALL become (winner+1) mod NCH; with no load, rr_ptr holds.
REQ-028 Latency: ARVALID SHALL rise 1 cycle after the grant; sustained throughput 1 AR/cycle while ARREADY=1.
REQ-029 Hold: while ARVALID=1 and ARREADY=0, ARID/ARADDR/ARLEN SHALL stay stable; ARVALID drops after a handshake with no new load.
REQ-030 ARID SHALL equal {winner[CHW-1:0], usr_arid[winner]}.
REQ-031 R routing (combinational, 0 latency): ch=RID[AXI_IW-1 -: CHW]; usr_rvalid[ch]=RVALID, other usr_rvalid bits 0; RREADY=usr_rready[ch]; usr_rid=RID[UIW-1:0]; usr_rdata/rresp/rlast SHALL be driven directly from RDATA/RRESP/RLAST.
REQ-032 Unmapped channel (ch>=NCH): RREADY=1, beat dropped, no usr_rvalid.
REQ-033 out_cnt[i]: +1 on grant to i, -1 on R handshake with RLAST=1 routed to i; both in the same cycle: unchanged; width $clog2(AMI_OD+1); never exceeds AMI_OD; a decrement at 0 SHALL saturate at 0.
REQ-034 stat_err[i] SHALL set on any R handshake routed to i with RRESP[1]=1, and clears only on reset.

Reset
REQ-035 On ARESET=1 at a clock edge: ARVALID=0, ARID/ARADDR/ARLEN=0, all out_cnt=0, rr_ptr=0, stat_err=0, usr_arready=0 the following cycle; mid-burst reset discards all in-flight tracking, and the system resets the slave together with this block.

Verification
REQ-036 All NCH=4 ports request continuously, ARREADY=1 -> grants cycle in order 0,1,2,3,0; one AR per cycle.
REQ-037 Port 1 issues 4 ARs with no R returned (AMI_OD=4) -> 5th request blocked (usr_arready[1]=0); after one RLAST to port 1 the 5th is granted.
REQ-038 ARREADY=0 for 5 cycles with ARVALID=1 -> ARID/ARADDR/ARLEN unchanged for all 5 cycles, no extra grant.
REQ-039 R beat RID=8'hC5 (NCH=4, UIW=6) -> usr_rvalid=4'b1000, usr_rid=6'h05, RREADY follows usr_rready[3].
REQ-040 RRESP=2'b10 on a port-2 beat -> stat_err=4'b0100 and held until ARESET; same-cycle grant and RLAST on port 0 -> out_cnt[0] unchanged.
